csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file_pkg.sv | 42 ++++
 rtl/csr_sat_counter.sv | 36 +++
 rtl/csr_file.sv | 187 ++++++++++++++++++
 tb/tb_csr_file.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// ---------------------------------------------------------------------------
// csr_file_pkg
// Shared definitions for the accelerator control/status register file:
//   - host-interface state encoding
//   - CTRL register bit positions
//   - fixed register indices and helpers that locate the EVENT, SCALAR and
//     pointer regions from the block parameters
// ---------------------------------------------------------------------------
package csr_file_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } csr_state_e;

  localparam int CTRL_LAUNCH_BIT = 0;
  localparam int CTRL_DONE_BIT   = 1;
  localparam int CTRL_BUSY_BIT   = 2;
  localparam int CTRL_IRQEN_BIT  = 3;

  localparam int CTRL_IDX   = 0;
  localparam int CYCLES_IDX = 1;

  function automatic int event_base();
    return CYCLES_IDX + 1;
  endfunction

  function automatic int scalar_base(input int num_event);
    return event_base() + num_event;
  endfunction

  // Each pointer occupies two consecutive words: lsb word, then msb word.
  function automatic int ptr_base(input int num_event, input int num_scalar);
    return scalar_base(num_event) + num_scalar;
  endfunction

  function automatic int num_regs(input int num_event, input int num_scalar,
                                  input int num_ptr);
    return ptr_base(num_event, num_scalar) + 2 * num_ptr;
  endfunction

endpackage

// File: rtl/csr_sat_counter.sv
// ---------------------------------------------------------------------------
// csr_sat_counter
// Saturating up-counter used for the CYCLES and EVENT registers.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   i_clear        : synchronous clear, wins over i_inc
//   i_inc          : add one this cycle (holds at all-ones)
//   o_count        : current count
// ---------------------------------------------------------------------------
module csr_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
// Host-visible register file controlling one accelerator.
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   host_req_*          : request (valid, opcode 1=write, byte addr, data)
//   host_req_deq        : request consumed this cycle
//   host_resp_*         : one-cycle read response (valid, data, bad address)
//   launch / finish     : start pulse out, done pulse in
//   busy / irq          : accelerator running, level interrupt
//   event_inc           : per-event-counter increment strobes
//   scalar / baddr      : flattened scalar and pointer registers, index 0 LSBs
// ---------------------------------------------------------------------------
module csr_file
  import csr_file_pkg::*;
#(
  parameter int HOST_ADDR_BITS = 8,
  parameter int HOST_DATA_BITS = 32,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int NUM_EVENT      = 2,
  parameter int NUM_SCALAR     = 2,
  parameter int NUM_PTR        = 2
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 host_req_valid,
  input  logic                                 host_req_opcode,
  input  logic [HOST_ADDR_BITS-1:0]            host_req_addr,
  input  logic [HOST_DATA_BITS-1:0]            host_req_value,
  output logic                                 host_req_deq,
  output logic                                 host_resp_valid,
  output logic [HOST_DATA_BITS-1:0]            host_resp_bits,
  output logic                                 host_resp_err,
  output logic                                 launch,
  input  logic                                 finish,
  output logic                                 busy,
  output logic                                 irq,
  input  logic [NUM_EVENT-1:0]                 event_inc,
  output logic [NUM_SCALAR*HOST_DATA_BITS-1:0] scalar,
  output logic [NUM_PTR*MEM_ADDR_BITS-1:0]     baddr
);

  localparam int IDX_BITS = HOST_ADDR_BITS - 2;
  localparam int SCL_BASE = scalar_base(NUM_EVENT);
  localparam int PTR_BASE = ptr_base(NUM_EVENT, NUM_SCALAR);
  localparam int NUM_REGS = num_regs(NUM_EVENT, NUM_SCALAR, NUM_PTR);

  csr_state_e r_state, w_state_nxt;

  logic                      w_deq, w_wr, w_rd, w_hit, w_ctrl_wr;
  logic [31:0]               w_idx32;
  logic                      w_launch_go, w_finish_go;
  logic                      w_busy_nxt, w_done_nxt, w_irq_en_nxt;
  logic [HOST_DATA_BITS-1:0] w_rdata;
  logic                      w_rerr;

  logic                      r_busy, r_done, r_irq_en, r_launch, r_irq;
  logic [HOST_DATA_BITS-1:0] r_rdata;
  logic                      r_rerr;
  logic [HOST_DATA_BITS-1:0] r_scalar [NUM_SCALAR];
  logic [HOST_DATA_BITS-1:0] r_ptr    [2*NUM_PTR];
  // Entry 0 is CYCLES, entry 1+j is EVENT[j].
  logic [HOST_DATA_BITS-1:0] w_cnt    [NUM_EVENT+1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_deq = host_req_valid;
        if (host_req_valid && !host_req_opcode) w_state_nxt = ST_READ;
      end
      ST_READ: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wr = w_deq && host_req_opcode;
  assign w_rd = w_deq && !host_req_opcode;

  // Word index zero-extended to 32 bits so it compares cleanly with ints.
  assign w_idx32 = {{(32-IDX_BITS){1'b0}}, host_req_addr[HOST_ADDR_BITS-1:2]};
  assign w_hit   = (host_req_addr[1:0] == 2'b00) && (w_idx32 < NUM_REGS);

  assign w_ctrl_wr   = w_wr && w_hit && (w_idx32 == CTRL_IDX);
  assign w_launch_go = w_ctrl_wr && host_req_value[CTRL_LAUNCH_BIT] && !r_busy;
  assign w_finish_go = finish && r_busy;

  // A completion in the same cycle as a done write-1-to-clear leaves done set.
  assign w_done_nxt = w_finish_go ? 1'b1 :
                      (w_launch_go || (w_ctrl_wr && host_req_value[CTRL_DONE_BIT])) ? 1'b0 :
                      r_done;
  assign w_busy_nxt   = w_launch_go ? 1'b1 : (w_finish_go ? 1'b0 : r_busy);
  assign w_irq_en_nxt = w_ctrl_wr ? host_req_value[CTRL_IRQEN_BIT] : r_irq_en;

  always_comb begin
    w_rdata = '0;
    w_rerr  = 1'b0;
    if (!w_hit) begin
      w_rerr = 1'b1;
    end else if (w_idx32 == CTRL_IDX) begin
      w_rdata[CTRL_DONE_BIT]  = r_done;
      w_rdata[CTRL_BUSY_BIT]  = r_busy;
      w_rdata[CTRL_IRQEN_BIT] = r_irq_en;
    end else begin
      for (int k = 0; k <= NUM_EVENT; k++)
        if (w_idx32 == CYCLES_IDX + k) w_rdata = w_cnt[k];
      for (int k = 0; k < NUM_SCALAR; k++)
        if (w_idx32 == SCL_BASE + k) w_rdata = r_scalar[k];
      for (int k = 0; k < 2*NUM_PTR; k++)
        if (w_idx32 == PTR_BASE + k) w_rdata = r_ptr[k];
    end
  end

  // irq is registered from the next-state values so it always equals done & irq_en.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
      r_launch <= 1'b0;
      r_irq    <= 1'b0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_launch <= w_launch_go;
      r_irq    <= w_done_nxt & w_irq_en_nxt;
      if (w_rd) begin
        r_rdata <= w_rdata;
        r_rerr  <= w_rerr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SCALAR; k++) r_scalar[k] <= '0;
      for (int k = 0; k < 2*NUM_PTR; k++)  r_ptr[k]    <= '0;
    end else if (w_wr && w_hit) begin
      for (int k = 0; k < NUM_SCALAR; k++)
        if (w_idx32 == SCL_BASE + k) r_scalar[k] <= host_req_value;
      for (int k = 0; k < 2*NUM_PTR; k++)
        if (w_idx32 == PTR_BASE + k) r_ptr[k] <= host_req_value;
    end
  end

  for (genvar g = 0; g <= NUM_EVENT; g++) begin : g_cnt
    logic w_inc;
    if (g == 0) begin : g_cycles
      assign w_inc = r_busy;
    end else begin : g_event
      assign w_inc = event_inc[g-1] & r_busy;
    end
    csr_sat_counter #(.WIDTH(HOST_DATA_BITS)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .i_clear (w_launch_go),
      .i_inc   (w_inc),
      .o_count (w_cnt[g])
    );
  end

  for (genvar g = 0; g < NUM_SCALAR; g++) begin : g_scalar
    assign scalar[g*HOST_DATA_BITS +: HOST_DATA_BITS] = r_scalar[g];
  end

  for (genvar g = 0; g < NUM_PTR; g++) begin : g_ptr
    assign baddr[g*MEM_ADDR_BITS +: MEM_ADDR_BITS] = {r_ptr[2*g+1], r_ptr[2*g]};
  end

  assign host_req_deq    = w_deq;
  assign host_resp_valid = (r_state == ST_READ);
  assign host_resp_bits  = r_rdata;
  assign host_resp_err   = r_rerr;
  assign launch          = r_launch;
  assign busy            = r_busy;
  assign irq             = r_irq;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file
// Self-checking bench for csr_file: directed vector table, hand-written
// launch/irq/reset sequences, randomized traffic against a register-level
// reference model, and a narrow-width instance for counter saturation.
// ---------------------------------------------------------------------------
module tb_csr_file;

  localparam int NE   = 2;
  localparam int NS   = 2;
  localparam int NP   = 2;
  localparam int NREG = 2 + NE + NS + 2*NP;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          host_req_valid = 1'b0;
  logic          host_req_opcode = 1'b0;
  logic [7:0]    host_req_addr = '0;
  logic [31:0]   host_req_value = '0;
  logic          host_req_deq;
  logic          host_resp_valid;
  logic [31:0]   host_resp_bits;
  logic          host_resp_err;
  logic          launch;
  logic          finish = 1'b0;
  logic          busy;
  logic          irq;
  logic [NE-1:0] event_inc = '0;
  logic [NS*32-1:0] scalar;
  logic [NP*64-1:0] baddr;

  // Narrow instance: lets an 8-bit counter reach saturation in a short run.
  logic          s_valid = 1'b0, s_opcode = 1'b0;
  logic [7:0]    s_addr = '0, s_value = '0;
  logic          s_deq, s_resp_valid, s_resp_err, s_launch, s_busy, s_irq;
  logic [7:0]    s_resp_bits;
  logic [NE-1:0] s_event_inc = '0;
  logic [NS*8-1:0]  s_scalar;
  logic [NP*16-1:0] s_baddr;

  always #5 clock = ~clock;

  csr_file dut (
    .clock(clock), .reset_n(reset_n),
    .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
    .host_req_addr(host_req_addr), .host_req_value(host_req_value),
    .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
    .host_resp_bits(host_resp_bits), .host_resp_err(host_resp_err),
    .launch(launch), .finish(finish), .busy(busy), .irq(irq),
    .event_inc(event_inc), .scalar(scalar), .baddr(baddr)
  );

  csr_file #(.HOST_DATA_BITS(8), .MEM_ADDR_BITS(16)) dut8 (
    .clock(clock), .reset_n(reset_n),
    .host_req_valid(s_valid), .host_req_opcode(s_opcode),
    .host_req_addr(s_addr), .host_req_value(s_value),
    .host_req_deq(s_deq), .host_resp_valid(s_resp_valid),
    .host_resp_bits(s_resp_bits), .host_resp_err(s_resp_err),
    .launch(s_launch), .finish(1'b0), .busy(s_busy), .irq(s_irq),
    .event_inc(s_event_inc), .scalar(s_scalar), .baddr(s_baddr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: register array indexed by word number, CTRL as fields.
  logic        m_busy, m_done, m_irq_en, m_launch, m_reading, m_rerr;
  logic [31:0] m_rdata;
  logic [31:0] m_reg [NREG];

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_irq_en = 0; m_launch = 0;
    m_reading = 0; m_rerr = 0; m_rdata = '0;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
  endtask

  task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    int idx;
    idx = int'(a[7:2]);
    d = '0; e = 0;
    if (a[1:0] != 2'b00 || idx >= NREG) e = 1;
    else if (idx == 0) d = {28'b0, m_irq_en, m_busy, m_done, 1'b0};
    else d = m_reg[idx];
  endtask

  task automatic sat_inc(input int i);
    if (m_reg[i] != 32'hFFFF_FFFF) m_reg[i] = m_reg[i] + 32'd1;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic deq, fin, go, w1c, hit;
    int idx;
    deq = host_req_valid && !m_reading;
    idx = int'(host_req_addr[7:2]);
    hit = (host_req_addr[1:0] == 2'b00) && (idx < NREG);
    if (deq && !host_req_opcode) model_read(host_req_addr, m_rdata, m_rerr);
    m_reading = deq && !host_req_opcode;
    fin = finish && m_busy;
    go = 0; w1c = 0;
    if (m_busy) begin
      sat_inc(1);
      for (int j = 0; j < NE; j++) if (event_inc[j]) sat_inc(2 + j);
    end
    if (deq && host_req_opcode && hit) begin
      if (idx == 0) begin
        w1c = host_req_value[1];
        m_irq_en = host_req_value[3];
        go = host_req_value[0] && !m_busy;
      end else if (idx >= 2 + NE) begin
        m_reg[idx] = host_req_value;
      end
    end
    if (go) begin
      m_busy = 1;
      for (int i = 1; i <= 1 + NE; i++) m_reg[i] = '0;
    end
    if (fin) begin m_busy = 0; m_done = 1; end
    else if (go || w1c) m_done = 0;
    m_launch = go;
  endtask

  task automatic check_outputs();
    logic [NS*32-1:0] es;
    logic [NP*64-1:0] eb;
    for (int k = 0; k < NS; k++)   es[k*32 +: 32] = m_reg[2 + NE + k];
    for (int k = 0; k < 2*NP; k++) eb[k*32 +: 32] = m_reg[2 + NE + NS + k];
    chk("launch", launch, m_launch);
    chk("busy", busy, m_busy);
    chk("irq", irq, m_done & m_irq_en);
    chk("resp_valid", host_resp_valid, m_reading);
    if (m_reading) begin
      chk("resp_bits", host_resp_bits, m_rdata);
      chk("resp_err", host_resp_err, m_rerr);
    end
    chk("scalar", scalar, es);
    chk("baddr", baddr, eb);
  endtask

  task automatic step();
    #1;
    chk("deq", host_req_deq, host_req_valid && !m_reading);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] v);
    host_req_valid = 1; host_req_opcode = 1; host_req_addr = a; host_req_value = v;
    step();
    host_req_valid = 0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    host_req_valid = 1; host_req_opcode = 0; host_req_addr = a;
    step();
    host_req_valid = 0;
    d = host_resp_bits; e = host_resp_err;
    chk("rd_resp_valid", host_resp_valid, 1'b1);
    step();
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_launch"}, launch, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_irq"}, irq, 1'b0);
    chk({tag, "_resp_valid"}, host_resp_valid, 1'b0);
    chk({tag, "_resp_bits"}, host_resp_bits, 32'd0);
    chk({tag, "_resp_err"}, host_resp_err, 1'b0);
    chk({tag, "_scalar"}, scalar, '0);
    chk({tag, "_baddr"}, baddr, '0);
  endtask

  // Asserts reset mid-cycle, checks outputs immediately, releases after 2 edges.
  task automatic mid_reset(input string tag);
    #2;
    reset_n = 0; host_req_valid = 0; finish = 0; event_inc = '0;
    model_reset();
    #1;
    check_reset_zero(tag);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] val;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 9) < 8) return 8'($urandom_range(0, NREG - 1) * 4);
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [31:0] d;
    logic        e;
    logic [7:0]  a;
    logic [31:0] v;
    int          n_sat;

    tbl[0]  = '{1'b1, 8'h10, 32'd5,          32'd0,          1'b0};
    tbl[1]  = '{1'b0, 8'h10, 32'd0,          32'd5,          1'b0};
    tbl[2]  = '{1'b1, 8'h08, 32'd5,          32'd0,          1'b0};
    tbl[3]  = '{1'b0, 8'h08, 32'd0,          32'd0,          1'b0};
    tbl[4]  = '{1'b0, 8'h02, 32'd0,          32'd0,          1'b1};
    tbl[5]  = '{1'b0, 8'hFC, 32'd0,          32'd0,          1'b1};
    tbl[6]  = '{1'b1, 8'h04, 32'd7,          32'd0,          1'b0};
    tbl[7]  = '{1'b0, 8'h04, 32'd0,          32'd0,          1'b0};
    tbl[8]  = '{1'b1, 8'h14, 32'hDEAD_BEEF,  32'd0,          1'b0};
    tbl[9]  = '{1'b0, 8'h14, 32'd0,          32'hDEAD_BEEF,  1'b0};
    tbl[10] = '{1'b1, 8'h18, 32'h1111_2222,  32'd0,          1'b0};
    tbl[11] = '{1'b1, 8'h24, 32'h9999_0000,  32'd0,          1'b0};
    tbl[12] = '{1'b0, 8'h24, 32'd0,          32'h9999_0000,  1'b0};
    tbl[13] = '{1'b0, 8'h28, 32'd0,          32'd0,          1'b1};
    tbl[14] = '{1'b0, 8'h00, 32'd0,          32'd0,          1'b0};
    tbl[15] = '{1'b1, 8'h00, 32'h8,          32'd0,          1'b0};
    tbl[16] = '{1'b0, 8'h00, 32'd0,          32'h8,          1'b0};
    tbl[17] = '{1'b1, 8'h00, 32'h0,          32'd0,          1'b0};

    model_reset();
    #3;
    check_reset_zero("por");
    @(posedge clock); #1;
    reset_n = 1;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) begin
        host_write(tbl[i].addr, tbl[i].val);
      end else begin
        host_read(tbl[i].addr, d, e);
        chk($sformatf("vec%0d_data", i), d, tbl[i].exp);
        chk($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
      end
    end

    // Launch, relaunch attempt while busy, then finish.
    host_write(8'h00, 32'h1);
    chk("launch_pulse", launch, 1'b1);
    step();
    chk("launch_one_cycle", launch, 1'b0);
    host_write(8'h00, 32'h1);
    chk("launch_while_busy", launch, 1'b0);
    idle(7);
    finish = 1; step(); finish = 0;
    chk("finish_busy", busy, 1'b0);
    host_read(8'h04, d, e);
    chk("cycles_range", (d >= 32'd9) && (d <= 32'd11), 1'b1);
    host_read(8'h00, d, e);
    chk("ctrl_done", d, 32'h2);
    host_write(8'h04, 32'd7);
    host_read(8'h04, d, e);
    chk("cycles_ro", d, 32'd10);

    // Interrupt and done/finish priority.
    host_write(8'h00, 32'h8);
    host_write(8'h00, 32'h9);
    idle(3);
    finish = 1; step(); finish = 0;
    chk("irq_set", irq, 1'b1);
    host_write(8'h00, 32'hA);
    chk("irq_cleared", irq, 1'b0);
    host_write(8'h00, 32'h9);
    idle(3);
    finish = 1;
    host_write(8'h00, 32'hA);
    finish = 0;
    chk("irq_prio", irq, 1'b1);
    host_read(8'h00, d, e);
    chk("done_prio", d, 32'hA);

    // Reset during a read response.
    host_req_valid = 1; host_req_opcode = 0; host_req_addr = 8'h10;
    step();
    mid_reset("rst_read");
    idle(3);

    // Reset while busy.
    host_write(8'h00, 32'h1);
    idle(2);
    mid_reset("rst_busy");
    idle(3);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_launch", launch, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      event_inc = NE'($urandom_range(0, 3));
      finish = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: step();
        1: begin
          a = pick_addr();
          v = $urandom;
          if (a == 8'h00) v = 32'($urandom_range(0, 15));
          host_write(a, v);
        end
        default: host_read(pick_addr(), d, e);
      endcase
    end
    finish = 0; event_inc = '0;
    idle(2);

    // Saturation on the 8-bit instance.
    s_valid = 1; s_opcode = 1; s_addr = 8'h00; s_value = 8'h01;
    @(posedge clock); #1;
    s_valid = 0; s_event_inc = 2'b01;
    chk("sat_launch", s_launch, 1'b1);
    n_sat = 300;
    repeat (n_sat - 1) @(posedge clock);
    #1;
    s_valid = 1; s_opcode = 0; s_addr = 8'h08;
    @(posedge clock); #1;
    s_valid = 0;
    chk("sat_resp_valid", s_resp_valid, 1'b1);
    chk("sat_event0", s_resp_bits, (n_sat > 255) ? 8'hFF : 8'(n_sat));
    @(posedge clock); #1;
    s_valid = 1; s_addr = 8'h0C;
    @(posedge clock); #1;
    s_valid = 0;
    chk("sat_event1", s_resp_bits, 8'h00);
    @(posedge clock); #1;
    s_valid = 1; s_addr = 8'h04;
    @(posedge clock); #1;
    s_valid = 0;
    chk("sat_cycles", s_resp_bits, 8'hFF);
    chk("sat_busy", s_busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
